lsu_axi_gpio_bridge: RTL

- AXI4 write-channel slave sitting directly downstream of the core's LSU AXI master, inside the user project.
- Replaces the ad-hoc wvalid/wstrb decoding and the free-running bvalid with a protocol-correct single-outstanding write slave.
- Decodes writes into three memory-mapped registers: GPIO output data, GPIO output-enable (active-low) and an LA mirror word.
- Returns a proper B response with ID echo.

---
 rtl/lsu_gpio_pkg.sv | 23 ++
 rtl/lsu_gpio_regfile.sv | 58 +++++
 rtl/lsu_axi_gpio_bridge.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/lsu_gpio_pkg.sv
// Shared constants and types for the LSU AXI write slave that drives the
// GPIO output, GPIO output-enable and LA mirror registers.
package lsu_gpio_pkg;

    // Byte offsets of the registers inside the 16-byte window. OUT and OEB
    // share one 64-bit beat (low and high lanes); LA sits in the upper beat.
    localparam logic [3:0] OFF_OUT = 4'h0;
    localparam logic [3:0] OFF_OEB = 4'h4;
    localparam logic [3:0] OFF_LA  = 4'h8;

    // AXI B-channel response codes.
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // Write-slave sequencing.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_RESP    = 2'd2
    } state_e;

endpackage

// File: rtl/lsu_gpio_regfile.sv
// GPIO output / output-enable / LA mirror registers with byte-strobe merge.
// A single commit pulse writes whichever lanes the strobes select; sel_la_i
// chooses between the OUT/OEB beat and the LA beat.
module lsu_gpio_regfile #(
    parameter int GPIO_W = 28
) (
    input  logic              clk,
    input  logic              srst,
    input  logic              commit_i,
    input  logic              sel_la_i,
    input  logic [63:0]       wdata_i,
    input  logic [7:0]        wstrb_i,
    output logic [GPIO_W-1:0] gpio_out_o,
    output logic [GPIO_W-1:0] gpio_oeb_o,
    output logic [31:0]       la_word_o
);

    logic [GPIO_W-1:0] out_q, out_d;
    logic [GPIO_W-1:0] oeb_q, oeb_d;
    logic [31:0]       la_q,  la_d;

    // Data bits beyond the GPIO width in each lane have no register behind them.
    logic unused_wdata;
    assign unused_wdata = ^wdata_i;

    // Per-bit merge: a bit takes new data only when its byte lane is strobed.
    genvar gi;
    generate
        for (gi = 0; gi < GPIO_W; gi++) begin : g_gpio_bit
            assign out_d[gi] = (commit_i && !sel_la_i && wstrb_i[gi/8])
                               ? wdata_i[gi] : out_q[gi];
            assign oeb_d[gi] = (commit_i && !sel_la_i && wstrb_i[4 + gi/8])
                               ? wdata_i[32 + gi] : oeb_q[gi];
        end
        for (gi = 0; gi < 32; gi++) begin : g_la_bit
            assign la_d[gi] = (commit_i && sel_la_i && wstrb_i[gi/8])
                              ? wdata_i[gi] : la_q[gi];
        end
    endgenerate

    // Register state; pads default to inputs (oeb all ones) out of reset.
    always_ff @(posedge clk) begin
        if (srst) begin
            out_q <= '0;
            oeb_q <= '1;
            la_q  <= '0;
        end else begin
            out_q <= out_d;
            oeb_q <= oeb_d;
            la_q  <= la_d;
        end
    end

    assign gpio_out_o = out_q;
    assign gpio_oeb_o = oeb_q;
    assign la_word_o  = la_q;

endmodule

// File: rtl/lsu_axi_gpio_bridge.sv
// Single-outstanding AXI4 write slave fronting the GPIO / LA registers.
// AW and W are accepted independently; the write commits on the edge where
// both are held, and a B response with the echoed ID is returned.
module lsu_axi_gpio_bridge
    import lsu_gpio_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h2000_0000,
    parameter int          GPIO_W    = 28,
    parameter int          ID_W      = 3
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              axi_awvalid,
    output logic              axi_awready,
    input  logic [ID_W-1:0]   axi_awid,
    input  logic [31:0]       axi_awaddr,
    input  logic [7:0]        axi_awlen,
    input  logic              axi_wvalid,
    output logic              axi_wready,
    input  logic [63:0]       axi_wdata,
    input  logic [7:0]        axi_wstrb,
    input  logic              axi_wlast,
    output logic              axi_bvalid,
    input  logic              axi_bready,
    output logic [1:0]        axi_bresp,
    output logic [ID_W-1:0]   axi_bid,
    output logic [GPIO_W-1:0] gpio_out,
    output logic [GPIO_W-1:0] gpio_oeb,
    output logic [31:0]       la_word,
    output logic              wr_pulse
);

    state_e            state_q;

    // AW hold: ID, decode result, lane select, burst flag.
    logic              aw_held_q,  aw_held_d;
    logic [ID_W-1:0]   awid_q,     awid_d;
    logic              aw_match_q, aw_match_d;
    logic              aw_lane_q,  aw_lane_d;
    logic              aw_err_q,   aw_err_d;

    // W hold: first beat captured, stream finished, burst-on-W flag.
    logic              w_beat_q,   w_beat_d;
    logic              w_done_q,   w_done_d;
    logic              w_err_q,    w_err_d;
    logic [63:0]       wdata_q,    wdata_d;
    logic [7:0]        wstrb_q,    wstrb_d;

    logic              bvalid_q;
    logic [1:0]        bresp_q;
    logic [ID_W-1:0]   bid_q;
    logic              wr_pulse_q;

    logic              aw_hs, w_hs, commit, reg_we, any_byte;
    logic [1:0]        resp;

    // Byte offset within a beat does not affect lane placement.
    logic unused_addr;
    assign unused_addr = ^axi_awaddr[2:0];

    // Readies depend only on registered state and reset.
    assign axi_awready = ~aw_held_q & ~wb_rst_i & (state_q != ST_RESP);
    assign axi_wready  = ~w_done_q  & ~wb_rst_i & (state_q != ST_RESP);

    assign aw_hs = axi_awvalid & axi_awready;
    assign w_hs  = axi_wvalid  & axi_wready;

    // Next hold values including this cycle's handshakes, plus commit decode.
    always_comb begin
        aw_held_d  = aw_held_q;
        awid_d     = awid_q;
        aw_match_d = aw_match_q;
        aw_lane_d  = aw_lane_q;
        aw_err_d   = aw_err_q;
        w_beat_d   = w_beat_q;
        w_done_d   = w_done_q;
        w_err_d    = w_err_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        if (aw_hs) begin
            aw_held_d  = 1'b1;
            awid_d     = axi_awid;
            aw_match_d = (axi_awaddr[31:4] == BASE_ADDR[31:4]);
            aw_lane_d  = (axi_awaddr[3] == OFF_LA[3]);
            aw_err_d   = (axi_awlen != 8'd0);
        end
        if (w_hs) begin
            // Only the first beat carries usable data; later beats of an
            // (unsupported) burst are drained until wlast.
            if (!w_beat_q) begin
                w_beat_d = 1'b1;
                wdata_d  = axi_wdata;
                wstrb_d  = axi_wstrb;
                w_err_d  = ~axi_wlast;
            end
            if (axi_wlast) begin
                w_done_d = 1'b1;
            end
        end

        commit = (state_q != ST_RESP) & aw_held_d & w_done_d;

        if (aw_err_d || w_err_d) begin
            resp = RESP_SLVERR;
        end else if (!aw_match_d) begin
            resp = RESP_DECERR;
        end else begin
            resp = RESP_OKAY;
        end

        any_byte = aw_lane_d ? (|wstrb_d[3:0]) : (|wstrb_d);
        reg_we   = commit & (resp == RESP_OKAY) & any_byte;
    end

    // Transaction sequencing, holds and registered B-channel outputs.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q    <= ST_IDLE;
            aw_held_q  <= 1'b0;
            awid_q     <= '0;
            aw_match_q <= 1'b0;
            aw_lane_q  <= 1'b0;
            aw_err_q   <= 1'b0;
            w_beat_q   <= 1'b0;
            w_done_q   <= 1'b0;
            w_err_q    <= 1'b0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            bvalid_q   <= 1'b0;
            bresp_q    <= RESP_OKAY;
            bid_q      <= '0;
            wr_pulse_q <= 1'b0;
        end else begin
            wr_pulse_q <= 1'b0;
            unique case (state_q)
                ST_IDLE, ST_COLLECT: begin
                    aw_held_q  <= aw_held_d;
                    awid_q     <= awid_d;
                    aw_match_q <= aw_match_d;
                    aw_lane_q  <= aw_lane_d;
                    aw_err_q   <= aw_err_d;
                    w_beat_q   <= w_beat_d;
                    w_done_q   <= w_done_d;
                    w_err_q    <= w_err_d;
                    wdata_q    <= wdata_d;
                    wstrb_q    <= wstrb_d;
                    if (commit) begin
                        state_q    <= ST_RESP;
                        bvalid_q   <= 1'b1;
                        bresp_q    <= resp;
                        bid_q      <= awid_d;
                        wr_pulse_q <= reg_we;
                    end else if (aw_hs || w_hs) begin
                        state_q <= ST_COLLECT;
                    end
                end
                ST_RESP: begin
                    if (axi_bready) begin
                        state_q   <= ST_IDLE;
                        bvalid_q  <= 1'b0;
                        aw_held_q <= 1'b0;
                        aw_err_q  <= 1'b0;
                        w_beat_q  <= 1'b0;
                        w_done_q  <= 1'b0;
                        w_err_q   <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign axi_bvalid = bvalid_q;
    assign axi_bresp  = bresp_q;
    assign axi_bid    = bid_q;
    assign wr_pulse   = wr_pulse_q;

    lsu_gpio_regfile #(
        .GPIO_W(GPIO_W)
    ) u_regfile (
        .clk        (wb_clk_i),
        .srst       (wb_rst_i),
        .commit_i   (reg_we),
        .sel_la_i   (aw_lane_d),
        .wdata_i    (wdata_d),
        .wstrb_i    (wstrb_d),
        .gpio_out_o (gpio_out),
        .gpio_oeb_o (gpio_oeb),
        .la_word_o  (la_word)
    );

endmodule
